// File: rtl/exception_controller_if.sv
// exception_controller_if: exception sources, PC and redirect/flush controls between pipeline and exception controller.
// EC_exc_count exists only when EXC_COUNTER_EN is defined.
interface exception_controller_if;
  logic        EC_overflow;
  logic        EC_invalid_addr;
  logic        EC_div_zero;
  logic        EC_control;
  logic        EC_write2_0;
  logic [31:0] EC_pc;
  logic        EC_eret;
  logic        EC_flush;
  logic        EC_stall;
  logic        EC_pc_sel;
  logic [31:0] EC_pc_target;
  logic [31:0] EC_epc;
  logic [2:0]  EC_cause;
  logic        EC_busy;
  logic        EC_double_fault;
`ifdef EXC_COUNTER_EN
  logic [15:0] EC_exc_count;
`endif
  modport master (
    output EC_overflow, EC_invalid_addr, EC_div_zero, EC_control, EC_write2_0, EC_pc, EC_eret,
    input  EC_flush, EC_stall, EC_pc_sel, EC_pc_target, EC_epc, EC_cause, EC_busy, EC_double_fault
`ifdef EXC_COUNTER_EN
    , input EC_exc_count
`endif
  );
  modport slave (
    input  EC_overflow, EC_invalid_addr, EC_div_zero, EC_control, EC_write2_0, EC_pc, EC_eret,
    output EC_flush, EC_stall, EC_pc_sel, EC_pc_target, EC_epc, EC_cause, EC_busy, EC_double_fault
`ifdef EXC_COUNTER_EN
    , output EC_exc_count
`endif
  );
endinterface

// File: rtl/exception_controller.sv
// exception_controller: prioritised exception capture and flush/redirect/return sequencing for the MIPS pipeline.
// Define EXC_COUNTER_EN to add the saturating accepted-exception counter EC_exc_count.
module exception_controller #(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic EC_clk,
  input logic EC_rst_n,
  exception_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FLUSH, REDIRECT, HANDLER, RETURN} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] epc;
  logic [2:0] cause, prio;
  logic double_fault, src;
  assign src = bus.EC_overflow | bus.EC_invalid_addr | bus.EC_div_zero | bus.EC_control | bus.EC_write2_0;
  assign prio = bus.EC_invalid_addr ? 3'd1 :
                bus.EC_div_zero     ? 3'd2 :
                bus.EC_overflow     ? 3'd3 :
                bus.EC_control      ? 3'd4 :
                bus.EC_write2_0     ? 3'd5 : 3'd0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = src ? FLUSH : IDLE;
      FLUSH:    state_nx = (cnt == 4'd0) ? REDIRECT : FLUSH;
      REDIRECT: state_nx = HANDLER;
      HANDLER:  state_nx = bus.EC_eret ? RETURN : HANDLER;
      RETURN:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge EC_clk or negedge EC_rst_n) begin
    if (!EC_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      epc          <= '0;
      cause        <= '0;
      double_fault <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && src) begin
        epc   <= bus.EC_pc;
        cause <= prio;
        cnt   <= 4'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // eret on the same edge as a source takes precedence over the fault
      if (state == HANDLER && src && !bus.EC_eret) double_fault <= 1'b1;
      else if (state == RETURN) double_fault <= 1'b0;
    end
  end
  assign bus.EC_flush        = state == FLUSH;
  assign bus.EC_stall        = state == FLUSH;
  assign bus.EC_pc_sel       = state == REDIRECT || state == RETURN;
  assign bus.EC_pc_target    = state == REDIRECT ? HANDLER_ADDR : state == RETURN ? epc : 32'h0;
  assign bus.EC_busy         = state == HANDLER || state == RETURN;
  assign bus.EC_epc          = epc;
  assign bus.EC_cause        = cause;
  assign bus.EC_double_fault = double_fault;
`ifdef EXC_COUNTER_EN
  logic [15:0] exc_count;
  always_ff @(posedge EC_clk or negedge EC_rst_n) begin
    if (!EC_rst_n) exc_count <= '0;
    else if (state == IDLE && src && exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
  end
  assign bus.EC_exc_count = exc_count;
`endif
endmodule

// File: tb/tb_exception_controller.sv
// tb_exception_controller: directed and randomized checks of exception_controller against a timeline-based reference model.
module tb_exception_controller;
  localparam logic [31:0] HA = 32'h8000_0180;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  exception_controller_if ifc();
  exception_controller #(.HANDLER_ADDR(HA), .FLUSH_CYCLES(FC)) dut (
    .EC_clk(clk),
    .EC_rst_n(rst_n),
    .bus(ifc.slave)
  );
  int vectors = 0;
  int miscompares = 0;
  // model: edge index of accepted exception and of accepted eret (-1 = none)
  int edge_n = 0;
  int acc = -1;
  int ret = -1;
  logic [31:0] m_epc = '0;
  logic [2:0] m_cause = '0;
  logic m_df = 1'b0;
  int m_cnt = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [2:0] cause_of(logic [4:0] s);
    logic [2:0] c = 3'd0;
    for (int i = 4; i >= 0; i--) if (s[i]) c = 3'(i + 1);
    return c;
  endfunction
  task automatic model_reset();
    acc = -1;
    ret = -1;
    m_epc = '0;
    m_cause = '0;
    m_df = 1'b0;
    m_cnt = 0;
  endtask
  task automatic check_all();
    int d = edge_n - acc;
    bit act = acc >= 0 && ret < 0;
    bit redir = act && d == FC;
    bit rtn = ret >= 0;
    chk("flush", 32'(ifc.EC_flush), 32'(act && d < FC));
    chk("stall", 32'(ifc.EC_stall), 32'(act && d < FC));
    chk("pc_sel", 32'(ifc.EC_pc_sel), 32'(redir || rtn));
    chk("pc_target", ifc.EC_pc_target, redir ? HA : (rtn ? m_epc : 32'h0));
    chk("busy", 32'(ifc.EC_busy), 32'((act && d > FC) || rtn));
    chk("epc", ifc.EC_epc, m_epc);
    chk("cause", 32'(ifc.EC_cause), 32'(m_cause));
    chk("double_fault", 32'(ifc.EC_double_fault), 32'(m_df));
`ifdef EXC_COUNTER_EN
    chk("exc_count", 32'(ifc.EC_exc_count), 32'(m_cnt));
`endif
  endtask
  // drive inputs, take one rising edge, advance the model, check 1 time unit later
  task automatic tick(logic [4:0] s, logic [31:0] p, logic e);
    bit idle = acc < 0;
    bit handler = acc >= 0 && ret < 0 && (edge_n - acc) > FC;
    bit rtn = ret >= 0;
    {ifc.EC_write2_0, ifc.EC_control, ifc.EC_overflow, ifc.EC_div_zero, ifc.EC_invalid_addr} = s;
    ifc.EC_pc = p;
    ifc.EC_eret = e;
    @(posedge clk);
    if (rst_n) begin
      edge_n++;
      if (rtn) begin
        acc = -1;
        ret = -1;
        m_df = 1'b0;
      end else if (idle && s != 5'd0) begin
        acc = edge_n;
        m_epc = p;
        m_cause = cause_of(s);
        if (m_cnt < 65535) m_cnt++;
      end else if (handler) begin
        if (e) ret = edge_n;
        else if (s != 5'd0) m_df = 1'b1;
      end
    end
    #1 check_all();
  endtask
  task automatic async_reset();
    rst_n = 1'b0;
    #1 model_reset();
    check_all();
    rst_n = 1'b1;
  endtask
  initial begin
    {ifc.EC_write2_0, ifc.EC_control, ifc.EC_overflow, ifc.EC_div_zero, ifc.EC_invalid_addr} = 5'h1f;
    ifc.EC_pc = 32'hdead_beef;
    ifc.EC_eret = 1'b1;
    #1 check_all();
    repeat (3) tick(5'h1f, 32'hdead_beef, 1'b1);
    rst_n = 1'b1;
    tick(5'd0, 32'h0, 1'b0);
    tick(5'b00010, 32'h0000_0040, 1'b0);
    repeat (4) tick(5'd0, 32'h0, 1'b0);
    chk("dz_epc", ifc.EC_epc, 32'h40);
    chk("dz_cause", 32'(ifc.EC_cause), 32'd2);
    chk("dz_busy", 32'(ifc.EC_busy), 32'd1);
    tick(5'b01000, 32'h99, 1'b0);
    chk("df_set", 32'(ifc.EC_double_fault), 32'd1);
    chk("df_cause", 32'(ifc.EC_cause), 32'd2);
    tick(5'd0, 32'h0, 1'b0);
    tick(5'd0, 32'h0, 1'b1);
    chk("ret_target", ifc.EC_pc_target, 32'h40);
    tick(5'd0, 32'h0, 1'b0);
    chk("df_clear", 32'(ifc.EC_double_fault), 32'd0);
    tick(5'b10101, 32'h0000_0100, 1'b0);
    chk("prio_cause", 32'(ifc.EC_cause), 32'd1);
    repeat (4) tick(5'd0, 32'h0, 1'b0);
    tick(5'b00100, 32'h44, 1'b1);
    chk("eret_wins", 32'(ifc.EC_double_fault), 32'd0);
    tick(5'd0, 32'h0, 1'b0);
    tick(5'b00001, 32'h0000_0200, 1'b0);
    async_reset();
    chk("rst_flush", 32'(ifc.EC_flush), 32'd0);
    chk("rst_epc", ifc.EC_epc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(5'b10000, 32'(k * 4 + 32'h300), 1'b0);
      repeat (3) tick(5'd0, 32'h0, 1'b0);
      if (k == 1) tick(5'b00100, 32'h0, 1'b0);
      tick(5'd0, 32'h0, 1'b1);
      tick(5'd0, 32'h0, 1'b0);
    end
`ifdef EXC_COUNTER_EN
    chk("count_3", 32'(ifc.EC_exc_count), 32'd3);
`endif
    repeat (600) begin
      logic [4:0] s = ($urandom % 3 == 0) ? 5'($urandom) : 5'd0;
      logic e = ($urandom % 3 == 0);
      if ($urandom % 80 == 0) async_reset();
      tick(s, $urandom, e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
